// File: rtl/ram512_arbiter.sv
// ============================================================================
// ram512_arbiter : two-port round-robin arbiter in front of a 512x16 RAM
//                  (write on rising edge, combinational read). Optional
//                  power-up clear of the whole RAM when INIT_CLEAR_EN is defined.
// Revision       : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ram512_arbiter (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        req0,
    input  logic        we0,
    input  logic [8:0]  addr0,
    input  logic [15:0] wdata0,
    output logic        gnt0,
    output logic        rvalid0,
    output logic [15:0] rdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic [8:0]  addr1,
    input  logic [15:0] wdata1,
    output logic        gnt1,
    output logic        rvalid1,
    output logic [15:0] rdata1,
    output logic [15:0] ram_in,
    output logic        ram_load,
    output logic [8:0]  ram_address,
    input  logic [15:0] ram_out,
    output logic        busy
);

    logic        run;
    logic        ptr_q, ptr_d;
    logic        arb_gnt0, arb_gnt1;
    logic [8:0]  addr_q, mux_addr;
    logic [15:0] din_q, mux_din;
    logic        mux_load;
    logic        rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [15:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

`ifdef INIT_CLEAR_EN
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0] state_q, state_d;
    logic [8:0] clr_cnt_q, clr_cnt_d;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + 9'd1;
            if (clr_cnt_q == 9'd511) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= 9'd0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign run  = (state_q == ST_RUN);
    assign busy = ~run;
`else
    assign run  = 1'b1;
    assign busy = 1'b0;
`endif

    // Raw grants stay free of RESET_N so no flop data path sees the async reset.
    assign arb_gnt0 = run & req0 & (~req1 | ~ptr_q);
    assign arb_gnt1 = run & req1 & (~req0 |  ptr_q);

    // Pointer moves to the loser only when both ports contend.
    assign ptr_d = (run & req0 & req1) ? arb_gnt0 : ptr_q;

    always_comb begin
        mux_addr = addr_q;
        mux_din  = din_q;
        mux_load = 1'b0;
        if (arb_gnt0) begin
            mux_addr = addr0;
            mux_din  = wdata0;
            mux_load = we0;
        end else if (arb_gnt1) begin
            mux_addr = addr1;
            mux_din  = wdata1;
            mux_load = we1;
        end
`ifdef INIT_CLEAR_EN
        if (state_q == ST_CLEAR) begin
            mux_addr = clr_cnt_q;
            mux_din  = 16'h0000;
            mux_load = 1'b1;
        end
`endif
    end

    always_comb begin
        rvalid0_d = arb_gnt0 & ~we0;
        rvalid1_d = arb_gnt1 & ~we1;
        rdata0_d  = rvalid0_d ? ram_out : rdata0_q;
        rdata1_d  = rvalid1_d ? ram_out : rdata1_q;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ptr_q     <= 1'b0;
            addr_q    <= 9'd0;
            din_q     <= 16'h0000;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= 16'h0000;
            rdata1_q  <= 16'h0000;
        end else begin
            ptr_q     <= ptr_d;
            addr_q    <= mux_addr;
            din_q     <= mux_din;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    // RAM-side and grant outputs are forced low asynchronously while in reset.
    assign gnt0        = RESET_N & arb_gnt0;
    assign gnt1        = RESET_N & arb_gnt1;
    assign ram_load    = RESET_N & mux_load;
    assign ram_address = RESET_N ? mux_addr : 9'd0;
    assign ram_in      = RESET_N ? mux_din  : 16'h0000;

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

`default_nettype wire
